// File: rtl/mux_sel_scanner.sv
// mux_sel_scanner: walks the 2-bit select of a 4:1 channel mux, holds each
// select for SETTLE_CYC+1 cycles, samples the mux output at the end of each
// window and presents the assembled 4-bit word with a valid/ready handshake.
// Optional build macro SCAN_AUTO_EN: a completed handshake immediately starts
// the next scan instead of returning to IDLE.
module mux_sel_scanner #(
    parameter int unsigned SETTLE_CYC = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [1:0] mux_sel,
    input  logic       mux_out,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] SETTLE_RELOAD = SETTLE_CYC[7:0];

    state_t     state_q, state_d;
    logic [1:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic [3:0] shadow_q, shadow_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;

    // Register every piece of state, so the select seen by the mux is glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            sel_q    <= 2'd0;
            cnt_q    <= 8'd0;
            shadow_q <= 4'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Next-state logic: the word only becomes visible on the edge entering HOLD
    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        data_d   = data_q;
        valid_d  = valid_q;

        unique case (state_q)
            IDLE: begin
                sel_d   = 2'd0;
                valid_d = 1'b0;
                if (start) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_RELOAD;
                end
            end

            SETTLE: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    shadow_d[sel_q] = mux_out;
                    if (sel_q != 2'd3) begin
                        sel_d = sel_q + 2'd1;
                        cnt_d = SETTLE_RELOAD;
                    end else begin
                        state_d = HOLD;
                        data_d  = {mux_out, shadow_q[2:0]};
                        valid_d = 1'b1;
                        sel_d   = 2'd0;
                    end
                end
            end

            HOLD: begin
                sel_d = 2'd0;
                if (valid_q && ready) begin
                    valid_d = 1'b0;
`ifdef SCAN_AUTO_EN
                    state_d = SETTLE;
                    cnt_d   = SETTLE_RELOAD;
`else
                    state_d = IDLE;
`endif
                end
            end

            default: begin
                state_d = IDLE;
                sel_d   = 2'd0;
                valid_d = 1'b0;
            end
        endcase
    end

    assign mux_sel = sel_q;
    assign data    = data_q;
    assign valid   = valid_q;
    assign busy    = (state_q == SETTLE);

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Testbench for mux_sel_scanner: one instance at the default settle time and
// one with SETTLE_CYC=0, each fed by a behavioural 4:1 mux.
module tb_mux_sel_scanner;

    logic       clk;
    logic       rst_n;

    logic       start1, ready1, valid1, busy1;
    logic [1:0] sel1;
    logic [3:0] data1, muxIn1;
    logic       muxOut1;

    logic       start0, ready0, valid0, busy0;
    logic [1:0] sel0;
    logic [3:0] data0, muxIn0;
    logic       muxOut0;

    int assertCount = 0;
    int failCount   = 0;

    assign muxOut1 = muxIn1[sel1];
    assign muxOut0 = muxIn0[sel0];

    mux_sel_scanner dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start1),
        .mux_sel (sel1),
        .mux_out (muxOut1),
        .data    (data1),
        .valid   (valid1),
        .ready   (ready1),
        .busy    (busy1)
    );

    mux_sel_scanner #(.SETTLE_CYC(0)) dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start0),
        .mux_sel (sel0),
        .mux_out (muxOut0),
        .data    (data0),
        .valid   (valid0),
        .ready   (ready0),
        .busy    (busy0)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Single linear sequence of directed steps
    initial begin : applyStimulus
        int n;
        rst_n  = 1'b0;
        start1 = 1'b0; ready1 = 1'b0; muxIn1 = 4'b0000;
        start0 = 1'b0; ready0 = 1'b0; muxIn0 = 4'b0000;
        tick(); tick();

        // Reset state
        checkOutput("rstSel",   int'(sel1),   0);
        checkOutput("rstData",  int'(data1),  0);
        checkOutput("rstValid", int'(valid1), 0);
        checkOutput("rstBusy",  int'(busy1),  0);
        rst_n = 1'b1;
        tick();

        // Reset during channel 2 aborts the scan at once
        muxIn1 = 4'b0101;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick(); tick(); tick();
        checkOutput("midSel",  int'(sel1),  2);
        checkOutput("midBusy", int'(busy1), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abortSel",   int'(sel1),   0);
        checkOutput("abortData",  int'(data1),  0);
        checkOutput("abortValid", int'(valid1), 0);
        checkOutput("abortBusy",  int'(busy1),  0);
        tick();
        rst_n = 1'b1;
        tick();

        // Full scan at SETTLE_CYC=1, inputs 1010
        muxIn1 = 4'b1010;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("scanSel%0d", i),   int'(sel1),   i / 2);
            checkOutput($sformatf("scanBusy%0d", i),  int'(busy1),  1);
            checkOutput($sformatf("scanValid%0d", i), int'(valid1), 0);
            checkOutput($sformatf("scanData%0d", i),  int'(data1),  0);
            tick();
        end
        checkOutput("doneValid", int'(valid1), 1);
        checkOutput("doneData",  int'(data1),  4'b1010);
        checkOutput("doneBusy",  int'(busy1),  0);
        checkOutput("doneSel",   int'(sel1),   0);

        // Backpressure: start pulse and new inputs during HOLD change nothing
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                start1 = 1'b1;
                muxIn1 = 4'b1111;
            end
            if (i == 4) start1 = 1'b0;
            tick();
            checkOutput($sformatf("holdValid%0d", i), int'(valid1), 1);
            checkOutput($sformatf("holdData%0d", i),  int'(data1),  4'b1010);
            checkOutput($sformatf("holdSel%0d", i),   int'(sel1),   0);
            checkOutput($sformatf("holdBusy%0d", i),  int'(busy1),  0);
        end
        ready1 = 1'b1;
        tick();
        ready1 = 1'b0;
        checkOutput("ackValid", int'(valid1), 0);
        checkOutput("ackData",  int'(data1),  4'b1010);
`ifdef SCAN_AUTO_EN
        checkOutput("ackBusy", int'(busy1), 1);
`else
        checkOutput("ackBusy", int'(busy1), 0);
`endif

        // SETTLE_CYC=0 instance, inputs 0110, ready tied high
        muxIn0 = 4'b0110;
        ready0 = 1'b1;
        start0 = 1'b1;
        tick();
        start0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("fastSel%0d", i),   int'(sel0),   i);
            checkOutput($sformatf("fastBusy%0d", i),  int'(busy0),  1);
            checkOutput($sformatf("fastValid%0d", i), int'(valid0), 0);
            tick();
        end
        checkOutput("fastDoneValid", int'(valid0), 1);
        checkOutput("fastDoneData",  int'(data0),  4'b0110);
        tick();
        checkOutput("fastDropValid", int'(valid0), 0);
        checkOutput("fastDropData",  int'(data0),  4'b0110);
`ifdef SCAN_AUTO_EN
        checkOutput("fastIdleBusy", int'(busy0), 1);
`else
        checkOutput("fastIdleBusy", int'(busy0), 0);
`endif
        ready0 = 1'b0;

        // Fresh reset, then start held high with ready high
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        muxIn1 = 4'b1010;
        ready1 = 1'b1;
        start1 = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) tick();
        checkOutput("rptValid1", int'(valid1), 1);
        checkOutput("rptData1",  int'(data1),  4'b1010);
        muxIn1 = 4'b0011;
        tick();
        checkOutput("rptDrop", int'(valid1), 0);
`ifdef SCAN_AUTO_EN
        checkOutput("rptGapBusy", int'(busy1), 1);
`else
        checkOutput("rptGapBusy", int'(busy1), 0);
`endif
        tick();
        checkOutput("rptBusy2", int'(busy1), 1);
        n = 0;
        while (!valid1 && n < 20) begin
            tick();
            n++;
        end
`ifdef SCAN_AUTO_EN
        checkOutput("rptLatency", n, 7);
`else
        checkOutput("rptLatency", n, 8);
`endif
        checkOutput("rptData2", int'(data1), 4'b0011);
        start1 = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
